// File: rtl/id_operand_fetch_pkg.sv
// Shared constants for the operand-fetch stage and the decoder/EX stages that pack and unpack
// the pass-through control bundle.
package id_operand_fetch_pkg;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic [4:0]  RegZeroAddr = 5'd0;

  // Control bundle layout: {aluop, alusel, wd, wreg}, wreg in bit 0.
  localparam int unsigned CtrlWregBit   = 0;
  localparam int unsigned CtrlWdLsb     = 1;
  localparam int unsigned CtrlWdW       = 5;
  localparam int unsigned CtrlAluselLsb = 6;
  localparam int unsigned CtrlAluselW   = 3;
  localparam int unsigned CtrlAluopLsb  = 9;
  localparam int unsigned CtrlAluopW    = 7;

endpackage

// File: rtl/id_operand_fetch_fwd_select.sv
// Resolves one source operand from immediate, r0, forwarding sources and register file,
// and flags a load-use hazard when the winning forwarding source is still pending.
module fwd_select
  import id_operand_fetch_pkg::*;
#(
  parameter int unsigned NFWD   = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic                     read,
  input  logic [REG_AW-1:0]        addr,
  input  logic [DATA_W-1:0]        imm,
  input  logic [DATA_W-1:0]        rf_data,
  input  logic [NFWD-1:0]          fwd_wreg,
  input  logic [NFWD*REG_AW-1:0]   fwd_wd,
  input  logic [NFWD*DATA_W-1:0]   fwd_wdata,
  input  logic [NFWD-1:0]          fwd_pending,
  output logic [DATA_W-1:0]        operand,
  output logic                     hazard
);

  always_comb begin
    operand = rf_data;
    hazard  = 1'b0;
    if (!read) begin
      operand = imm;
    end else if (addr == REG_AW'(RegZeroAddr)) begin
      operand = '0;
    end else begin
      // Walk oldest to youngest so the lowest matching index wins.
      for (int i = int'(NFWD) - 1; i >= 0; i--) begin
        if (fwd_wreg[i] && (fwd_wd[i*REG_AW +: REG_AW] == addr)) begin
          operand = fwd_wdata[i*DATA_W +: DATA_W];
          hazard  = fwd_pending[i];
        end
      end
    end
  end

endmodule

// File: rtl/id_operand_fetch.sv
// Operand fetch plus ID/EX pipeline register: resolves both sources, stalls on load-use,
// handshakes with decoder and EX, and counts hazard stall cycles.
module id_operand_fetch
  import id_operand_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned NFWD   = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic                     in_reg1_read,
  input  logic                     in_reg2_read,
  input  logic [REG_AW-1:0]        in_reg1_addr,
  input  logic [REG_AW-1:0]        in_reg2_addr,
  input  logic [DATA_W-1:0]        in_imm,
  input  logic [DATA_W-1:0]        rf_data1,
  input  logic [DATA_W-1:0]        rf_data2,
  input  logic [NFWD-1:0]          fwd_wreg,
  input  logic [NFWD*REG_AW-1:0]   fwd_wd,
  input  logic [NFWD*DATA_W-1:0]   fwd_wdata,
  input  logic [NFWD-1:0]          fwd_pending,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [DATA_W-1:0]        out_reg1,
  output logic [DATA_W-1:0]        out_reg2,
  input  logic                     clr_stats,
  output logic [CNT_W-1:0]         stall_cycles
);

  logic [DATA_W-1:0] opnd1, opnd2;
  logic              hazard1, hazard2, hazard, fire_in;

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] reg1_q, reg2_q;
  logic [CNT_W-1:0]  stall_q, stall_d;

  fwd_select #(
    .NFWD   (NFWD),
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_sel1 (
    .read        (in_reg1_read),
    .addr        (in_reg1_addr),
    .imm         (in_imm),
    .rf_data     (rf_data1),
    .fwd_wreg    (fwd_wreg),
    .fwd_wd      (fwd_wd),
    .fwd_wdata   (fwd_wdata),
    .fwd_pending (fwd_pending),
    .operand     (opnd1),
    .hazard      (hazard1)
  );

  fwd_select #(
    .NFWD   (NFWD),
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_sel2 (
    .read        (in_reg2_read),
    .addr        (in_reg2_addr),
    .imm         (in_imm),
    .rf_data     (rf_data2),
    .fwd_wreg    (fwd_wreg),
    .fwd_wd      (fwd_wd),
    .fwd_wdata   (fwd_wdata),
    .fwd_pending (fwd_pending),
    .operand     (opnd2),
    .hazard      (hazard2)
  );

  assign hazard   = hazard1 | hazard2;
  assign in_ready = !hazard && !flush && (!valid_q || out_ready);
  assign fire_in  = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (fire_in) begin
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (clr_stats) begin
      stall_d = '0;
    end else if (in_valid && hazard && !flush && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      reg1_q  <= '0;
      reg2_q  <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      stall_q <= stall_d;
      if (fire_in) begin
        ctrl_q <= in_ctrl;
        reg1_q <= opnd1;
        reg2_q <= opnd2;
      end
    end
  end

  assign out_valid    = valid_q;
  assign out_ctrl     = ctrl_q;
  assign out_reg1     = reg1_q;
  assign out_reg2     = reg2_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_id_operand_fetch.sv
// Directed bench for id_operand_fetch with an output scoreboard.
module tb_id_operand_fetch;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned NFWD   = 2;
  localparam int unsigned CNT_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid, in_ready;
  logic [CTRL_W-1:0]       in_ctrl;
  logic                    in_reg1_read, in_reg2_read;
  logic [REG_AW-1:0]       in_reg1_addr, in_reg2_addr;
  logic [DATA_W-1:0]       in_imm, rf_data1, rf_data2;
  logic [NFWD-1:0]         fwd_wreg, fwd_pending;
  logic [NFWD*REG_AW-1:0]  fwd_wd;
  logic [NFWD*DATA_W-1:0]  fwd_wdata;
  logic                    flush, out_valid, out_ready;
  logic [CTRL_W-1:0]       out_ctrl;
  logic [DATA_W-1:0]       out_reg1, out_reg2;
  logic                    clr_stats;
  logic [CNT_W-1:0]        stall_cycles;

  always #5 clk = ~clk;

  id_operand_fetch #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .CTRL_W (CTRL_W),
    .NFWD   (NFWD),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .in_reg1_read (in_reg1_read),
    .in_reg2_read (in_reg2_read),
    .in_reg1_addr (in_reg1_addr),
    .in_reg2_addr (in_reg2_addr),
    .in_imm       (in_imm),
    .rf_data1     (rf_data1),
    .rf_data2     (rf_data2),
    .fwd_wreg     (fwd_wreg),
    .fwd_wd       (fwd_wd),
    .fwd_wdata    (fwd_wdata),
    .fwd_pending  (fwd_pending),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (out_ctrl),
    .out_reg1     (out_reg1),
    .out_reg2     (out_reg2),
    .clr_stats    (clr_stats),
    .stall_cycles (stall_cycles)
  );

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
  } exp_t;

  exp_t              sb_q[$];
  int                checks = 0;
  int                errors = 0;
  logic [DATA_W-1:0] exp_r1, exp_r2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    in_valid     = 1'b0;
    in_ctrl      = '0;
    in_reg1_read = 1'b0;
    in_reg2_read = 1'b0;
    in_reg1_addr = '0;
    in_reg2_addr = '0;
    in_imm       = '0;
    rf_data1     = '0;
    rf_data2     = '0;
    fwd_wreg     = '0;
    fwd_wd       = '0;
    fwd_wdata    = '0;
    fwd_pending  = '0;
    flush        = 1'b0;
    clr_stats    = 1'b0;
  endtask

  // One clock: check in_ready, pop/compare any EX transfer, push an expected acceptance.
  task automatic cycle(input logic exp_ready, input logic chk_ready);
    exp_t e;
    @(negedge clk);
    if (chk_ready) chk("in_ready", 64'(in_ready), 64'(exp_ready));
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("out_valid_unexpected", 64'(out_valid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
        chk("out_reg1", 64'(out_reg1), 64'(e.r1));
        chk("out_reg2", 64'(out_reg2), 64'(e.r2));
      end
    end
    if (in_valid && exp_ready) sb_q.push_back('{ctrl: in_ctrl, r1: exp_r1, r2: exp_r2});
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    out_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_out_reg1", 64'(out_reg1), 64'd0);
    chk("rst_out_reg2", 64'(out_reg2), 64'd0);
    chk("rst_stall", 64'(stall_cycles), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;

    // Back-to-back ORI-style stream
    for (int i = 0; i < 4; i++) begin
      in_valid     = 1'b1;
      in_ctrl      = 16'h0100 + 16'(i);
      in_reg1_read = 1'b1;
      in_reg1_addr = 5'd3;
      rf_data1     = 32'h0000_1234 + 32'(i);
      in_imm       = 32'h0000_00FF + 32'(i);
      exp_r1       = 32'h0000_1234 + 32'(i);
      exp_r2       = 32'h0000_00FF + 32'(i);
      cycle(1'b1, 1'b1);
      if (i == 0) chk("latency_out_valid", 64'(out_valid), 64'd1);
    end

    // Forwarding priority: youngest source wins, then the older one when the youngest is off
    idle();
    in_valid     = 1'b1;
    in_ctrl      = 16'h0200;
    in_reg1_read = 1'b1;
    in_reg1_addr = 5'd5;
    rf_data1     = 32'h1111_1111;
    fwd_wreg     = 2'b11;
    fwd_wd       = {5'd5, 5'd5};
    fwd_wdata    = {32'hBBBB_0000, 32'hAAAA_0000};
    exp_r1       = 32'hAAAA_0000;
    exp_r2       = 32'h0;
    cycle(1'b1, 1'b1);
    in_ctrl  = 16'h0201;
    fwd_wreg = 2'b10;
    exp_r1   = 32'hBBBB_0000;
    cycle(1'b1, 1'b1);

    // r0 always reads zero, even with a matching forward
    idle();
    in_valid     = 1'b1;
    in_ctrl      = 16'h0300;
    in_reg2_read = 1'b1;
    in_reg2_addr = 5'd0;
    rf_data2     = 32'h2222_2222;
    in_imm       = 32'h7;
    fwd_wreg     = 2'b01;
    fwd_wd       = {5'd0, 5'd0};
    fwd_wdata    = {32'h0, 32'hDEAD_BEEF};
    exp_r1       = 32'h7;
    exp_r2       = 32'h0;
    cycle(1'b1, 1'b1);

    // Drain and clear the counter
    idle();
    clr_stats = 1'b1;
    cycle(1'b1, 1'b1);
    clr_stats = 1'b0;
    chk("stall_clr", 64'(stall_cycles), 64'd0);

    // Pending source shadowed by a younger non-pending match is no hazard
    fwd_wreg     = 2'b11;
    fwd_wd       = {5'd9, 5'd9};
    fwd_pending  = 2'b10;
    in_reg1_read = 1'b1;
    in_reg1_addr = 5'd9;
    cycle(1'b1, 1'b1);

    // Load-use: 2 stall cycles, 2 bubbles, then issue with forwarded 0x55
    idle();
    in_valid     = 1'b1;
    in_ctrl      = 16'h0400;
    in_reg1_read = 1'b1;
    in_reg1_addr = 5'd7;
    fwd_wreg     = 2'b01;
    fwd_wd       = {5'd0, 5'd7};
    fwd_pending  = 2'b01;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1);
      chk("bubble", 64'(out_valid), 64'd0);
    end
    chk("stall_two", 64'(stall_cycles), 64'd2);
    fwd_pending = 2'b00;
    fwd_wdata   = {32'h0, 32'h0000_0055};
    exp_r1      = 32'h55;
    exp_r2      = 32'h0;
    cycle(1'b1, 1'b1);
    chk("stall_hold", 64'(stall_cycles), 64'd2);

    // Backpressure: entry A held for 3 cycles while B waits
    idle();
    in_valid = 1'b1;
    in_ctrl  = 16'h0500;
    in_imm   = 32'hA5A5_0001;
    exp_r1   = 32'hA5A5_0001;
    exp_r2   = 32'hA5A5_0001;
    cycle(1'b1, 1'b1);
    out_ready = 1'b0;
    in_ctrl   = 16'h0501;
    in_imm    = 32'hB0B0_0002;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_ctrl", 64'(out_ctrl), 64'h0500);
      chk("bp_reg1", 64'(out_reg1), 64'hA5A5_0001);
      chk("bp_reg2", 64'(out_reg2), 64'hA5A5_0001);
    end

    // Flush kills held A and refuses B
    flush = 1'b1;
    cycle(1'b0, 1'b1);
    void'(sb_q.pop_front());
    chk("flush_valid", 64'(out_valid), 64'd0);
    idle();
    out_ready = 1'b1;
    cycle(1'b1, 1'b1);
    chk("flush_no_accept", 64'(out_valid), 64'd0);

    // Counter saturation with CNT_W=4
    in_valid     = 1'b1;
    in_reg2_read = 1'b1;
    in_reg2_addr = 5'd4;
    fwd_wreg     = 2'b10;
    fwd_wd       = {5'd4, 5'd0};
    fwd_pending  = 2'b10;
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);
    chk("stall_sat", 64'(stall_cycles), 64'd15);
    clr_stats = 1'b1;
    cycle(1'b0, 1'b1);
    chk("stall_clr_wins", 64'(stall_cycles), 64'd0);

    // Reset mid-transfer discards the entry; first post-reset instruction accepted at once
    idle();
    in_valid = 1'b1;
    in_ctrl  = 16'h0600;
    in_imm   = 32'hC0C0_0003;
    exp_r1   = 32'hC0C0_0003;
    exp_r2   = 32'hC0C0_0003;
    cycle(1'b1, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_reg1", 64'(out_reg1), 64'd0);
    sb_q.delete();
    #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 16'h0700;
    in_imm    = 32'hD0D0_0004;
    exp_r1    = 32'hD0D0_0004;
    exp_r2    = 32'hD0D0_0004;
    cycle(1'b1, 1'b1);
    chk("post_rst_valid", 64'(out_valid), 64'd1);

    // Bounded drain
    idle();
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) cycle(1'b1, 1'b0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
